div_32: RTL
===========

DIV_32 -- requirements
Module: div_32

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: dividend  input  32  numerator; captured on accepted start.
REQ-006 Port: divisor  input  32  denominator; captured on accepted start.
REQ-007 Port: busy  output  1  high in RUN and DONE states.
REQ-008 Port: done  output  1  one-cycle pulse; results valid from this cycle.
REQ-009 Port: quotient  output  32  registered quotient.
REQ-010 Port: remainder  output  32  registered remainder.
REQ-011 Port: div_by_zero  output  1  high with done when the captured divisor was 0; holds until next accepted start.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 IDLE + start=1 + divisor!=0 SHALL capture operands, clear the 6-bit iteration counter and go to RUN.
REQ-014 IDLE + start=1 + divisor==0 SHALL go to DONE next cycle with quotient=0xFFFFFFFF, remainder=dividend, div_by_zero=1.
REQ-015 Each RUN cycle SHALL perform one restoring step: partial remainder shifted left with the next dividend MSB; divisor subtracted on a 33-bit trial; if non-negative, keep the difference and shift in quotient bit 1, else restore and shift in 0.
REQ-016 RUN SHALL last exactly 32 cycles, then go to DONE; DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-017 Latency: start sampled at edge N -> done=1 during the cycle after edge N+33 (N+1 for divide-by-zero).
REQ-018 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-019 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-020 quotient, remainder and div_by_zero SHALL hold their DONE values until the next accepted start, and SHALL NOT change during RUN.
REQ-021 Operand inputs SHALL be don't-care except at the accepted-start edge.

Reset
REQ-022 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE with busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 and counter=0.
REQ-023 Reset during RUN or DONE SHALL abort the operation; no done pulse SHALL follow release.
REQ-024 The first start SHALL be accepted on the first rising edge after rst_n rises.

Configuration
REQ-025 Macro DIV_32_SIGNED_EN SHALL select the signedness of division.
REQ-026 Without DIV_32_SIGNED_EN, operands and results SHALL be unsigned.
REQ-027 With DIV_32_SIGNED_EN, operands SHALL be two's complement and the core SHALL divide magnitudes.
REQ-028 With DIV_32_SIGNED_EN, the quotient SHALL be negated when operand signs differ, and the remainder SHALL take the dividend's sign (truncating division).
REQ-029 With DIV_32_SIGNED_EN, 0x80000000 / 0xFFFFFFFF SHALL give quotient=0x80000000 and remainder=0 with div_by_zero=0.
REQ-030 With DIV_32_SIGNED_EN, sign fix-up SHALL occur in the DONE transition and latency SHALL be unchanged.
REQ-031 With DIV_32_SIGNED_EN, divide-by-zero behaviour SHALL be as in REQ-014.

Verification
REQ-032 Unsigned 100 / 7, start at edge 0 -> done at edge 33, quotient=14, remainder=2, div_by_zero=0.
REQ-033 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0; then 5 / 9 -> quotient=0, remainder=5.
REQ-034 0x1234 / 0 -> done one cycle after start, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
REQ-035 Start 100/7, then start 50/5 at cycle 10 -> ignored; one done only, with quotient=14 and remainder=2.
REQ-036 rst_n low at cycle 15 of RUN -> busy=0 and outputs=0 at once, no done pulse; next start 9/3 -> quotient=3, remainder=0.
REQ-037 With DIV_32_SIGNED_EN: -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.

Source files
------------

// File: rtl/div_32.sv
// Multi-cycle 32-bit restoring divider: IDLE -> RUN (32 steps) -> DONE.
// Define DIV_32_SIGNED_EN for two's complement truncating division; unsigned otherwise.
module div_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;   // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] step_work, step_rem;
  logic [WIDTH-1:0] op_a, op_b, q_fix, r_fix;

  // One restoring step; trial[WIDTH] is the borrow, since rem_q < dvs_q always holds.
  assign shifted   = {rem_q, work_q[WIDTH-1]};
  assign trial     = shifted - {1'b0, dvs_q};
  assign step_work = {work_q[WIDTH-2:0], ~trial[WIDTH]};
  assign step_rem  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

`ifdef DIV_32_SIGNED_EN
  logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;

  assign op_a  = dividend[WIDTH-1] ? -dividend : dividend;
  assign op_b  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign q_fix = neg_q_q ? -step_work : step_work;
  assign r_fix = neg_r_q ? -step_rem  : step_rem;

  always_comb begin
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    if (state_q == S_IDLE && start) begin
      neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r_d = dividend[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  assign op_a  = dividend;
  assign op_b  = divisor;
  assign q_fix = step_work;
  assign r_fix = step_rem;
`endif

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d   = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            work_d  = op_a;
            dvs_d   = op_b;
            rem_d   = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        work_d = step_work;
        rem_d  = step_rem;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          quo_d   = q_fix;
          rmd_d   = r_fix;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule
